// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory ports among NUM_CONSUMERS requesters with round-robin grants.
// Write path is built only when MEM_CHANNEL_ARBITER_WRITE_EN is defined.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
    } state_t;

    state_t                 state_q   [NUM_CHANNELS];
    logic [CW-1:0]          cons_q    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_q    [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   rdata_q   [NUM_CHANNELS];
    logic [CW-1:0]          grant_idx [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claim_q, claim_d, pending, want_write, taken;
    logic [NUM_CHANNELS-1:0]  grant_v, grant_wr;
    logic [CW-1:0]            rr_q, rr_d;
    int                       scan;
    logic                     found;

`ifdef MEM_CHANNEL_ARBITER_WRITE_EN
    logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
    assign pending    = consumer_read_valid | consumer_write_valid;
    // Reads win when a consumer raises both valids.
    assign want_write = ~consumer_read_valid & consumer_write_valid;
`else
    logic unused_write_inputs;
    assign pending             = consumer_read_valid;
    assign want_write          = '0;
    assign unused_write_inputs = ^{consumer_write_address, consumer_write_data,
                                   mem_write_ready, grant_wr};
`endif

    always_comb begin
        claim_d = claim_q;
        rr_d    = rr_q;
        taken   = '0;
        grant_v = '0;
        grant_wr = '0;
        scan    = 0;
        found   = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant_idx[c] = '0;
            if (state_q[c] == READ_RELAYING && !consumer_read_valid[cons_q[c]])
                claim_d[cons_q[c]] = 1'b0;
            if (state_q[c] == WRITE_RELAYING && !consumer_write_valid[cons_q[c]])
                claim_d[cons_q[c]] = 1'b0;
            if (state_q[c] == IDLE) begin
                found = 1'b0;
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    scan = (int'(rr_q) + k) % NUM_CONSUMERS;
                    // claim_q (not claim_d) keeps a just-released consumer out this cycle.
                    if (!found && pending[scan] && !claim_q[scan] && !taken[scan]) begin
                        found        = 1'b1;
                        taken[scan]  = 1'b1;
                        grant_v[c]   = 1'b1;
                        grant_wr[c]  = want_write[scan];
                        grant_idx[c] = CW'(scan);
                        claim_d[scan] = 1'b1;
                        rr_d         = CW'((scan + 1) % NUM_CONSUMERS);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            claim_q <= '0;
            rr_q    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
                cons_q[c]  <= '0;
                addr_q[c]  <= '0;
                rdata_q[c] <= '0;
`ifdef MEM_CHANNEL_ARBITER_WRITE_EN
                wdata_q[c] <= '0;
`endif
            end
        end else begin
            claim_q <= claim_d;
            rr_q    <= rr_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    IDLE: if (grant_v[c]) begin
                        cons_q[c] <= grant_idx[c];
`ifdef MEM_CHANNEL_ARBITER_WRITE_EN
                        if (grant_wr[c]) begin
                            state_q[c] <= WRITE_WAITING;
                            addr_q[c]  <= consumer_write_address[int'(grant_idx[c])*ADDR_BITS +: ADDR_BITS];
                            wdata_q[c] <= consumer_write_data[int'(grant_idx[c])*DATA_BITS +: DATA_BITS];
                        end else
`endif
                        begin
                            state_q[c] <= READ_WAITING;
                            addr_q[c]  <= consumer_read_address[int'(grant_idx[c])*ADDR_BITS +: ADDR_BITS];
                        end
                    end
                    READ_WAITING: if (mem_read_ready[c]) begin
                        rdata_q[c] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
                        state_q[c] <= READ_RELAYING;
                    end
                    WRITE_WAITING: begin
`ifdef MEM_CHANNEL_ARBITER_WRITE_EN
                        if (mem_write_ready[c]) state_q[c] <= WRITE_RELAYING;
`endif
                    end
                    READ_RELAYING:
                        if (!consumer_read_valid[cons_q[c]]) state_q[c] <= IDLE;
                    WRITE_RELAYING:
                        if (!consumer_write_valid[cons_q[c]]) state_q[c] <= IDLE;
                    default: state_q[c] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        mem_read_valid       = '0;
        mem_read_address     = '0;
        mem_write_valid      = '0;
        mem_write_address    = '0;
        mem_write_data       = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                READ_WAITING: begin
                    mem_read_valid[c] = 1'b1;
                    mem_read_address[c*ADDR_BITS +: ADDR_BITS] = addr_q[c];
                end
                READ_RELAYING: begin
                    consumer_read_ready[cons_q[c]] = 1'b1;
                    consumer_read_data[int'(cons_q[c])*DATA_BITS +: DATA_BITS] = rdata_q[c];
                end
`ifdef MEM_CHANNEL_ARBITER_WRITE_EN
                WRITE_WAITING: begin
                    mem_write_valid[c] = 1'b1;
                    mem_write_address[c*ADDR_BITS +: ADDR_BITS] = addr_q[c];
                    mem_write_data[c*DATA_BITS +: DATA_BITS]    = wdata_q[c];
                end
                WRITE_RELAYING: consumer_write_ready[cons_q[c]] = 1'b1;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Scoreboard bench for mem_channel_arbiter: a latency-configurable memory model answers
// each channel; expected read data / write beats are queued when requests are issued.
module tb_mem_channel_arbiter;
    localparam int AB = 8, DB = 16, NC = 4, NCH = 2;

    logic clk = 1'b0;
    logic reset;
    logic [NC-1:0]     consumer_read_valid, consumer_read_ready;
    logic [NC*AB-1:0]  consumer_read_address;
    logic [NC*DB-1:0]  consumer_read_data;
    logic [NC-1:0]     consumer_write_valid, consumer_write_ready;
    logic [NC*AB-1:0]  consumer_write_address;
    logic [NC*DB-1:0]  consumer_write_data;
    logic [NCH-1:0]    mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
    logic [NCH*AB-1:0] mem_read_address, mem_write_address;
    logic [NCH*DB-1:0] mem_read_data, mem_write_data;

    always #5 clk = ~clk;

    mem_channel_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready),
        .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data),
        .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid),
        .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .mem_write_ready(mem_write_ready)
    );

    typedef struct { int cons; logic [DB-1:0] data; } rd_exp_t;
    typedef struct { logic [AB-1:0] addr; logic [DB-1:0] data; } wr_exp_t;
    rd_exp_t rd_sb[$];
    wr_exp_t wr_sb[$];

    int n_checks = 0;
    int n_bad = 0;
    int mem_lat = 3;
    int rcnt[NCH];
    int wcnt[NCH];
    int rd_issued = 0;
    int hit;
    int snap;
    logic [AB-1:0] wseen_a[NCH];
    logic [DB-1:0] wseen_d[NCH];
    logic [DB-1:0] mem_img[256];
    logic [NCH-1:0] mrv_prev;
    logic [NC-1:0]  crr_prev;
    logic any_wr;
    wr_exp_t we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_mrv"}, 32'(mem_read_valid), 0);
        check_eq({tag, "_mra"}, 32'(mem_read_address), 0);
        check_eq({tag, "_mwv"}, 32'(mem_write_valid), 0);
        check_eq({tag, "_crr"}, 32'(consumer_read_ready), 0);
        check_eq({tag, "_crd"}, consumer_read_data[31:0] | consumer_read_data[63:32], 0);
        check_eq({tag, "_cwr"}, 32'(consumer_write_ready), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        mem_lat = 3;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // hold = number of cycles the consumer observes ready before dropping valid
    task automatic do_read(input int i, input logic [AB-1:0] a, input int hold);
        rd_exp_t e;
        int t;
        e.cons = i;
        e.data = mem_img[a];
        rd_sb.push_back(e);
        consumer_read_address[i*AB +: AB] = a;
        consumer_read_valid[i] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!consumer_read_ready[i] && t < 200);
        check_eq($sformatf("rd%0d_ready", i), 32'(consumer_read_ready[i]), 1);
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            check_eq($sformatf("rd%0d_hold", i), 32'(consumer_read_ready[i]), 1);
        end
        consumer_read_valid[i] = 1'b0;
        @(negedge clk);
        check_eq($sformatf("rd%0d_release", i), 32'(consumer_read_ready[i]), 0);
        consumer_read_address[i*AB +: AB] = '0;
    endtask

    task automatic do_write(input int i, input logic [AB-1:0] a, input logic [DB-1:0] d,
                            input int hold);
        wr_exp_t e;
        int t;
        e.addr = a;
        e.data = d;
        wr_sb.push_back(e);
        consumer_write_address[i*AB +: AB] = a;
        consumer_write_data[i*DB +: DB] = d;
        consumer_write_valid[i] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!consumer_write_ready[i] && t < 200);
        check_eq($sformatf("wr%0d_ready", i), 32'(consumer_write_ready[i]), 1);
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            check_eq($sformatf("wr%0d_hold", i), 32'(consumer_write_ready[i]), 1);
        end
        consumer_write_valid[i] = 1'b0;
        @(negedge clk);
        check_eq($sformatf("wr%0d_release", i), 32'(consumer_write_ready[i]), 0);
    endtask

    // Memory model and consumer-side monitor.
    initial begin
        mem_read_ready  = '0;
        mem_write_ready = '0;
        mem_read_data   = '0;
        mrv_prev = '0;
        crr_prev = '0;
        for (int c = 0; c < NCH; c++) begin
            rcnt[c] = 0;
            wcnt[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (mem_read_valid[c] && !mrv_prev[c]) rd_issued++;
                if (mem_read_ready[c] || reset || !mem_read_valid[c]) begin
                    mem_read_ready[c] = 1'b0;
                    rcnt[c] = 0;
                end else begin
                    rcnt[c]++;
                    if (rcnt[c] >= mem_lat) begin
                        mem_read_ready[c] = 1'b1;
                        mem_read_data[c*DB +: DB] = mem_img[mem_read_address[c*AB +: AB]];
                    end
                end
                if (mem_write_ready[c] || reset || !mem_write_valid[c]) begin
                    mem_write_ready[c] = 1'b0;
                    wcnt[c] = 0;
                end else begin
                    if (wcnt[c] == 0) begin
                        check_eq("wr_sb_hit", 32'(wr_sb.size()), 1);
                        if (wr_sb.size() > 0) begin
                            we = wr_sb.pop_front();
                            check_eq("wr_addr", 32'(mem_write_address[c*AB +: AB]), 32'(we.addr));
                            check_eq("wr_data", 32'(mem_write_data[c*DB +: DB]), 32'(we.data));
                        end
                        wseen_a[c] = mem_write_address[c*AB +: AB];
                        wseen_d[c] = mem_write_data[c*DB +: DB];
                    end else begin
                        check_eq("wr_addr_stable", 32'(mem_write_address[c*AB +: AB]),
                                 32'(wseen_a[c]));
                        check_eq("wr_data_stable", 32'(mem_write_data[c*DB +: DB]),
                                 32'(wseen_d[c]));
                    end
                    wcnt[c]++;
                    if (wcnt[c] >= mem_lat) mem_write_ready[c] = 1'b1;
                end
            end
            mrv_prev = mem_read_valid;
            for (int i = 0; i < NC; i++) begin
                if (consumer_read_ready[i] && !crr_prev[i]) begin
                    hit = -1;
                    for (int j = 0; j < rd_sb.size(); j++)
                        if (hit < 0 && rd_sb[j].cons == i) hit = j;
                    check_eq($sformatf("rd%0d_sb_hit", i), 32'(hit >= 0), 1);
                    if (hit >= 0) begin
                        check_eq($sformatf("rd%0d_data", i),
                                 32'(consumer_read_data[i*DB +: DB]), 32'(rd_sb[hit].data));
                        rd_sb.delete(hit);
                    end
                end
            end
            crr_prev = consumer_read_ready;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem_img[a] = 16'(a * 257) ^ 16'h5A3C;
        mem_img[8'h10] = 16'hBEEF;
        reset = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("rst");

        // Single read from consumer 2; channel 0 valid one cycle after the request.
        fork
            do_read(2, 8'h10, 1);
            begin
                @(negedge clk);
                check_eq("single_ch0_valid", 32'(mem_read_valid), 32'b01);
                check_eq("single_ch0_addr", 32'(mem_read_address[AB-1:0]), 32'h10);
            end
        join

        // Contention: all four request at once with rr_ptr at 0.
        do_reset();
        fork
            do_read(0, 8'h20, 1);
            do_read(1, 8'h21, 1);
            do_read(2, 8'h22, 1);
            do_read(3, 8'h23, 1);
            begin
                @(negedge clk);
                check_eq("cont_valid", 32'(mem_read_valid), 32'b11);
                check_eq("cont_ch0_addr", 32'(mem_read_address[AB-1:0]), 32'h20);
                check_eq("cont_ch1_addr", 32'(mem_read_address[2*AB-1:AB]), 32'h21);
            end
        join
        check_eq("cont_sb_empty", 32'(rd_sb.size()), 0);

`ifdef MEM_CHANNEL_ARBITER_WRITE_EN
        do_reset();
        do_write(1, 8'h3F, 16'h1234, 2);
        check_eq("wr_sb_empty", 32'(wr_sb.size()), 0);
`else
        do_reset();
        any_wr = 1'b0;
        consumer_write_address[AB-1:0] = 8'h3F;
        consumer_write_data[DB-1:0] = 16'h1234;
        consumer_write_valid[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            any_wr = any_wr | (|mem_write_valid) | consumer_write_ready[0] | (|mem_read_valid);
        end
        consumer_write_valid[0] = 1'b0;
        check_eq("wr_dis_quiet", 32'(any_wr), 0);
        check_eq("wr_dis_addr", 32'(mem_write_address), 0);
`endif

        // Reset while both channels wait; consumer 1 reissues and lands on channel 0.
        do_reset();
        mem_lat = 1000;
        consumer_read_address[AB-1:0] = 8'h40;
        consumer_read_address[2*AB-1:AB] = 8'h41;
        consumer_read_valid[1:0] = 2'b11;
        repeat (2) @(negedge clk);
        check_eq("rstw_both_wait", 32'(mem_read_valid), 32'b11);
        reset = 1'b1;
        consumer_read_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("rstw");
        begin
            rd_exp_t e;
            e.cons = 1;
            e.data = mem_img[8'h41];
            rd_sb.push_back(e);
        end
        @(negedge clk);
        check_eq("rstw_regrant_ch", 32'(mem_read_valid), 32'b01);
        check_eq("rstw_regrant_addr", 32'(mem_read_address[AB-1:0]), 32'h41);
        mem_lat = 3;
        snap = 0;
        while (!consumer_read_ready[1] && snap < 200) begin
            @(negedge clk);
            snap++;
        end
        check_eq("rstw_ready", 32'(consumer_read_ready[1]), 1);
        consumer_read_valid[1] = 1'b0;
        @(negedge clk);

        // Consumer 3 holds valid 5 cycles after ready; only one memory read may go out.
        do_reset();
        snap = rd_issued;
        do_read(3, 8'h55, 5);
        repeat (3) @(negedge clk);
        check_eq("hold_one_read", 32'(rd_issued - snap), 1);

        check_eq("final_rd_sb_empty", 32'(rd_sb.size()), 0);
        check_eq("final_wr_sb_empty", 32'(wr_sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_channel_arbiter.md
MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of requesting LSUs/fetchers.
REQ-004 SHALL have parameter NUM_CHANNELS, default 2, number of memory channels, 1..NUM_CONSUMERS.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-006 SHALL have consumer_read_valid (in, NUM_CONSUMERS), consumer_read_address (in, NUM_CONSUMERS*ADDR_BITS), consumer_read_ready (out, NUM_CONSUMERS) and consumer_read_data (out, NUM_CONSUMERS*DATA_BITS).
REQ-007 SHALL have consumer_write_valid (in, NUM_CONSUMERS), consumer_write_address (in, NUM_CONSUMERS*ADDR_BITS), consumer_write_data (in, NUM_CONSUMERS*DATA_BITS) and consumer_write_ready (out, NUM_CONSUMERS).
REQ-008 SHALL have mem_read_valid (out, NUM_CHANNELS), mem_read_address (out, NUM_CHANNELS*ADDR_BITS), mem_read_ready (in, NUM_CHANNELS) and mem_read_data (in, NUM_CHANNELS*DATA_BITS), connecting to mem_wrapper read ports.
REQ-009 SHALL have mem_write_valid (out, NUM_CHANNELS), mem_write_address (out, NUM_CHANNELS*ADDR_BITS), mem_write_data (out, NUM_CHANNELS*DATA_BITS) and mem_write_ready (in, NUM_CHANNELS).
REQ-010 SHALL pack every flattened bus with index i in bits [(i+1)*W-1 : i*W].

Function
REQ-011 SHALL give each channel a registered FSM with states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING and WRITE_RELAYING.
REQ-012 SHALL keep a claim bit per consumer; a claimed consumer is never granted to a second channel.
REQ-013 SHALL arbitrate once per cycle. IDLE channels, in ascending index order, each grant the first pending unclaimed consumer, scanning from rr_ptr and wrapping modulo NUM_CONSUMERS.
REQ-014 SHALL, when one or more grants occur, set rr_ptr to (last granted consumer + 1) mod NUM_CONSUMERS; otherwise rr_ptr is unchanged.
REQ-015 SHALL treat a consumer as pending if it has read_valid or write_valid; if both are asserted, the read is served first.
REQ-016 SHALL, on a grant, latch the address (and write data) in that cycle and enter READ_WAITING or WRITE_WAITING. mem_*_valid is asserted from the next cycle, giving one cycle of latency.
REQ-017 SHALL hold mem_*_valid, address and data stable in *_WAITING until mem_*_ready is sampled high.
REQ-018 SHALL, when mem_*_ready is sampled high, drop mem_*_valid and enter *_RELAYING in the next cycle. In that cycle it asserts consumer_*_ready; for reads it also drives consumer_read_data with the mem_read_data captured in the ready cycle.
REQ-019 SHALL hold consumer_*_ready high in *_RELAYING until the consumer's *_valid is sampled low. It then deasserts ready, clears the claim and returns to IDLE in the next cycle.
REQ-020 SHALL allow a released consumer to be granted again no earlier than the cycle after the release.
REQ-021 SHALL ignore mem_*_ready in any state other than the matching *_WAITING state.
REQ-022 SHALL drive unused outputs to 0: consumer ready/data when the consumer is unserved, and mem valid/address/data when the channel is IDLE.

Reset
REQ-023 SHALL, when reset is high at a rising clk edge, put every channel in IDLE, clear all claims and set rr_ptr to 0.
REQ-024 SHALL make every output 0 in the cycle after reset is sampled high.
REQ-025 SHALL, on reset during a transaction, abandon the transaction with no retry. The consumer must reissue its request.

Configuration
REQ-026 SHALL compile the write path in only when macro MEM_CHANNEL_ARBITER_WRITE_EN is defined.
REQ-027 SHALL, without MEM_CHANNEL_ARBITER_WRITE_EN, never enter the WRITE states, tie consumer_write_ready and all mem_write_* outputs to 0, ignore consumer_write_valid, and leave the ports present. This is the program-memory configuration.

Verification
REQ-028 SHALL cover single read: consumer 2 reads 0x10, memory returns 0xBEEF with ready after 3 cycles -> channel 0 valid at t+1, consumer_read_ready[2] with data 0xBEEF at ready+1, and release after valid drops.
REQ-029 SHALL cover contention: all 4 consumers issue reads in the same cycle with rr_ptr 0 -> channel 0 serves consumer 0, channel 1 serves consumer 1, rr_ptr becomes 2, and consumers 2/3 are granted as channels free up.
REQ-030 SHALL cover write (WRITE_EN defined): consumer 1 writes 0x1234 to 0x3F -> mem_write_valid with address 0x3F and data 0x1234 held until ready, then consumer_write_ready[1] pulses until valid drops.
REQ-031 SHALL cover write disabled (WRITE_EN undefined): consumer 0 asserts write_valid for 20 cycles -> mem_write_valid stays 0 and consumer_write_ready[0] stays 0.
REQ-032 SHALL cover reset in WAITING: reset asserted while channel 1 waits -> next cycle all outputs are 0 and claims are cleared; a reissued request is granted to channel 0.
REQ-033 SHALL cover a held consumer valid: consumer 3 keeps read_valid high for 5 cycles after ready -> ready stays high for 5 cycles and no second memory read is issued.
